timer_int_ctrl: RTL and testbench
=================================

TIMER_INT_CTRL -- requirements
Module: timer_int_ctrl

Interface
REQ-001 SHALL have port pclk, input, 1, single system clock; all logic on rising edge.
REQ-002 SHALL have port presetn, input, 1, synchronous active-low reset, sampled on pclk rising edge.
REQ-003 SHALL have ports psel/penable/pwrite, input, 1 each, APB control.
REQ-004 SHALL have ports paddr input 8 and pwdata input 8, APB address and write data.
REQ-005 SHALL have ports prdata output 8, pready output 1, pslverr output 1.
REQ-006 SHALL have ports ovf_i and udf_i, input, 1 each, timer TSR overflow and underflow status levels.
REQ-007 SHALL have port irq_o, output, 1, interrupt request to CPU.
REQ-008 SHALL have port irq_ack_i, input, 1, CPU acknowledge, one-cycle pulse.
REQ-009 SHALL have port vec_o, output, 8, vector of the request being serviced.

Function
REQ-010 SHALL complete APB access phase with pready=1 and zero wait states; write on psel&penable&pwrite.
REQ-011 SHALL drive prdata combinationally during the access phase; prdata=0 otherwise.
REQ-012 SHALL map IER at 0x00: bit0 OVFIE, bit1 UDFIE, rw, bits[7:2] read 0.
REQ-013 SHALL map ISR at 0x01: bit0 OVFF, bit1 UDFF, sticky; writing 1 to a bit clears it; writing 0 has no effect.
REQ-014 SHALL map IVR at 0x02, read-only, returning vec_o.
REQ-015 SHALL assert pslverr=1 with pready=1 for an unmapped address or a write to IVR; no register changes.
REQ-016 SHALL set OVFF/UDFF on a 0->1 edge of ovf_i/udf_i, via a registered previous value; the flag is visible one cycle after the edge.
REQ-017 SHALL give set priority when a set and a W1C hit the same bit in the same cycle.
REQ-018 SHALL run FSM IDLE/REQ/SERVICE; reset state IDLE.
REQ-019 IDLE: if (ISR&IER)!=0 -> REQ next cycle; SHALL latch vec_o=8'h10 (OVF) or 8'h11 (UDF); OVF has priority when both are pending.
REQ-020 REQ: irq_o=1 (registered); on irq_ack_i=1 -> SERVICE with irq_o=0 next cycle.
REQ-021 REQ: if the latched flag is cleared by a write, or its enable is cleared, before ack -> IDLE with irq_o=0, no ack required.
REQ-022 SERVICE: stay until the serviced ISR bit is 0 -> IDLE; any remaining pending enabled bit re-raises irq_o via IDLE->REQ.
REQ-023 SHALL ignore irq_ack_i in IDLE and SERVICE.
REQ-024 SHALL keep vec_o constant from REQ entry until the next REQ entry.

Reset
REQ-025 On presetn=0 at a clock edge: IER=0, ISR=0, edge registers=0, FSM=IDLE, irq_o=0, vec_o=8'h00, pslverr=0, and ECR=0 when present.
REQ-026 A reset asserted during REQ or SERVICE SHALL drop irq_o on the next edge; edges on ovf_i/udf_i already high at reset release SHALL NOT set flags.

Configuration
REQ-027 With TIMER_INT_EVCNT_EN defined: ECR at 0x03, 8-bit, increments on each detected OVF or UDF edge (+2 if both in one cycle), saturates at 8'hFF, and any write clears it to 0.
REQ-028 Without TIMER_INT_EVCNT_EN: 0x03 is unmapped (pslverr=1) and no counter logic exists.

Verification
REQ-029 IER=8'h02; pulse udf_i -> ISR=8'h02 after 1 cycle, irq_o=1 after 2, IVR=8'h11; ack -> irq_o=0; write ISR=8'h02 -> ISR=8'h00, FSM IDLE.
REQ-030 IER=8'h03; ovf_i and udf_i rise in the same cycle -> vec_o=8'h10 first; after ack and OVF clear, irq_o re-asserts with vec_o=8'h11.
REQ-031 IER=8'h00; pulse ovf_i -> ISR=8'h01, irq_o stays 0; then write IER=8'h01 -> irq_o=1.
REQ-032 W1C of UDFF in the same cycle as a udf_i edge -> UDFF remains 1.
REQ-033 Read 0x04 -> pslverr=1, prdata=0; write to 0x02 -> pslverr=1, IVR unchanged.
REQ-034 With the macro: 300 OVF edges -> ECR=8'hFF; write 0x03 -> ECR=8'h00; without the macro, read 0x03 -> pslverr=1.

Source files
------------

// File: rtl/timer_int_ctrl.sv
// Timer interrupt controller: APB-mapped IER/ISR/IVR, edge-detected OVF/UDF flags, IDLE/REQ/SERVICE request FSM.
// Optional event counter ECR at 0x03 is built only when TIMER_INT_EVCNT_EN is defined.
module timer_int_ctrl (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  input  logic       ovf_i,
  input  logic       udf_i,
  output logic       irq_o,
  input  logic       irq_ack_i,
  output logic [7:0] vec_o,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [1:0] ier, isr, isr_next, pend, set_bits, w1c_bits;
  logic       ovf_q, udf_q, armed;
  logic       ovf_edge, udf_edge;
  logic       svc_udf, svc_live, svc_flag, load_vec;
  logic       access, wr, bad;
  logic       sel_ier, sel_isr, sel_ivr, sel_ecr;
  logic       unused_wdata;

  // APB: valid access when psel & penable; always ready, errors flagged in the same access cycle.
  assign access  = psel & penable;
  assign wr      = access & pwrite & ~bad;
  assign sel_ier = (paddr == 8'h00);
  assign sel_isr = (paddr == 8'h01);
  assign sel_ivr = (paddr == 8'h02);
  assign bad     = ~(sel_ier | sel_isr | sel_ivr | sel_ecr) | (pwrite & sel_ivr);
  assign pready  = 1'b1;
  assign pslverr = access & bad;
  assign unused_wdata = ^pwdata[7:2];

  // armed stays low for the first cycle after reset so inputs already high are not seen as edges
  assign ovf_edge = armed & ovf_i & ~ovf_q;
  assign udf_edge = armed & udf_i & ~udf_q;
  assign set_bits = {udf_edge, ovf_edge};
  assign w1c_bits = (wr & sel_isr) ? pwdata[1:0] : 2'b00;
  assign isr_next = set_bits | (isr & ~w1c_bits);
  assign pend     = isr & ier;
  assign svc_live = svc_udf ? pend[1] : pend[0];
  assign svc_flag = svc_udf ? isr[1] : isr[0];

`ifdef TIMER_INT_EVCNT_EN
  logic [7:0] ecr;
  logic [8:0] ecr_sum;
  assign sel_ecr = (paddr == 8'h03);
  assign ecr_sum = {1'b0, ecr} + {8'd0, ovf_edge} + {8'd0, udf_edge};

  always_ff @(posedge pclk) begin
    if (!presetn)              ecr <= 8'h00;
    else if (wr && sel_ecr)    ecr <= 8'h00;
    else if (ecr_sum[8])       ecr <= 8'hFF;
    else                       ecr <= ecr_sum[7:0];
  end
`else
  assign sel_ecr = 1'b0;
`endif

  always_comb begin
    prdata = 8'h00;
    if (access && !pwrite && !bad) begin
      if (sel_ier)      prdata = {6'd0, ier};
      else if (sel_isr) prdata = {6'd0, isr};
      else if (sel_ivr) prdata = vec_o;
`ifdef TIMER_INT_EVCNT_EN
      else if (sel_ecr) prdata = ecr;
`endif
    end
  end

  always_comb begin
    state_next = state;
    load_vec   = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_next = REQ;
          load_vec   = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack_i)      state_next = SERVICE;
        else if (!svc_live) state_next = IDLE;
      end
      SERVICE: begin
        if (!svc_flag) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state   <= IDLE;
      ier     <= 2'b00;
      isr     <= 2'b00;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      armed   <= 1'b0;
      svc_udf <= 1'b0;
      vec_o   <= 8'h00;
    end else begin
      state <= state_next;
      isr   <= isr_next;
      ovf_q <= ovf_i;
      udf_q <= udf_i;
      armed <= 1'b1;
      if (wr && sel_ier) ier <= pwdata[1:0];
      // OVF wins when both are pending
      if (load_vec) begin
        svc_udf <= ~pend[0];
        vec_o   <= pend[0] ? 8'h10 : 8'h11;
      end
    end
  end

  assign irq_o     = (state == REQ);
  assign fsm_state = state;

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Bench for timer_int_ctrl: directed scenarios plus random traffic against a behavioural model.
// Define TIMER_INT_EVCNT_EN for both files to exercise the event counter.
module tb_timer_int_ctrl;

  logic       pclk, presetn, psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;
  logic       ovf_i, udf_i, irq_o, irq_ack_i;
  logic [7:0] vec_o;
  logic [1:0] fsm_state;

  int n_cmp = 0;
  int n_err = 0;

`ifdef TIMER_INT_EVCNT_EN
  localparam bit HAS_ECR = 1'b1;
`else
  localparam bit HAS_ECR = 1'b0;
`endif

  timer_int_ctrl dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .ovf_i(ovf_i), .udf_i(udf_i), .irq_o(irq_o), .irq_ack_i(irq_ack_i),
    .vec_o(vec_o), .fsm_state(fsm_state)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Behavioural model: flags, enables, and an "outstanding request" view of the interrupt line.
  logic [7:0] m_ier, m_isr, m_vec;
  int         m_ecr;
  bit         m_prev_ovf, m_prev_udf, m_armed;
  bit         m_wait_ack, m_in_service;
  int         m_svc;

  function automatic bit exp_err(input logic [7:0] a, input bit w);
    if (a == 8'h02 && w) return 1'b1;
    if (a <= 8'h02)      return 1'b0;
    if (a == 8'h03)      return !HAS_ECR;
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    case (a)
      8'h00:   return m_ier;
      8'h01:   return m_isr;
      8'h02:   return m_vec;
      8'h03:   return 8'(m_ecr);
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_update();
    bit eo, eu, wr;
    logic [7:0] old_isr, pend, w1c;
    if (!presetn) begin
      m_ier = 0; m_isr = 0; m_vec = 0; m_ecr = 0;
      m_prev_ovf = 0; m_prev_udf = 0; m_armed = 0;
      m_wait_ack = 0; m_in_service = 0; m_svc = 0;
      return;
    end
    eo = m_armed && ovf_i && !m_prev_ovf;
    eu = m_armed && udf_i && !m_prev_udf;
    wr = psel && penable && pwrite && !exp_err(paddr, 1'b1);
    old_isr = m_isr;
    pend = m_isr & m_ier;
    if (m_wait_ack) begin
      if (irq_ack_i) begin
        m_wait_ack = 0;
        m_in_service = 1;
      end else if (!pend[m_svc]) begin
        m_wait_ack = 0;
      end
    end else if (m_in_service) begin
      if (!old_isr[m_svc]) m_in_service = 0;
    end else if (pend != 0) begin
      m_wait_ack = 1;
      m_svc = pend[0] ? 0 : 1;
      m_vec = pend[0] ? 8'h10 : 8'h11;
    end
    w1c = (wr && paddr == 8'h01) ? (pwdata & 8'h03) : 8'h00;
    m_isr = (old_isr & ~w1c) | {6'd0, eu, eo};
    if (wr && paddr == 8'h00) m_ier = pwdata & 8'h03;
    if (HAS_ECR) begin
      if (wr && paddr == 8'h03) m_ecr = 0;
      else m_ecr = (m_ecr + int'(eo) + int'(eu) > 255) ? 255 : m_ecr + int'(eo) + int'(eu);
    end
    m_prev_ovf = ovf_i;
    m_prev_udf = udf_i;
    m_armed = 1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    model_update();
    @(negedge pclk);
    chk("irq_model", {7'd0, irq_o}, {7'd0, m_wait_ack});
    chk("vec_model", vec_o, m_vec);
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d, input bit rise_udf);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    step();
    penable = 1;
    if (rise_udf) udf_i = 1;
    #1;
    chk("wr_pslverr", {7'd0, pslverr}, {7'd0, exp_err(a, 1'b1)});
    chk("wr_pready", {7'd0, pready}, 8'h01);
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  // use_model selects the model's view at access time instead of the fixed value
  task automatic apb_read(input logic [7:0] a, input logic [7:0] exp, input bit use_model, input string tag);
    logic [7:0] want;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    step();
    penable = 1;
    #1;
    want = exp_err(a, 1'b0) ? 8'h00 : (use_model ? exp_rd(a) : exp);
    chk(tag, prdata, want);
    chk("rd_pslverr", {7'd0, pslverr}, {7'd0, exp_err(a, 1'b0)});
    step();
    psel = 0; penable = 0;
  endtask

  task automatic pulse_ovf();
    ovf_i = 1; step(); ovf_i = 0;
  endtask

  task automatic pulse_udf();
    udf_i = 1; step(); udf_i = 0;
  endtask

  task automatic ack();
    irq_ack_i = 1; step(); irq_ack_i = 0;
  endtask

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    udf_i = 0; irq_ack_i = 0;
    presetn = 0; ovf_i = 1;

    // reset values, with ovf_i held high across reset release
    repeat (3) step();
    chk("rst_irq", {7'd0, irq_o}, 8'h00);
    chk("rst_vec", vec_o, 8'h00);
    chk("rst_pslverr", {7'd0, pslverr}, 8'h00);
    chk("rst_prdata", prdata, 8'h00);
    presetn = 1;
    repeat (3) step();
    ovf_i = 0;
    apb_read(8'h01, 8'h00, 0, "isr_after_release");
    apb_read(8'h00, 8'h00, 0, "ier_after_reset");

    // UDF request, ack, W1C clear
    apb_write(8'h00, 8'h02, 0);
    udf_i = 1; step(); udf_i = 0;
    chk("udf_irq_1cyc", {7'd0, irq_o}, 8'h00);
    step();
    chk("udf_irq_2cyc", {7'd0, irq_o}, 8'h01);
    apb_read(8'h01, 8'h02, 0, "udf_isr");
    apb_read(8'h02, 8'h11, 0, "udf_ivr");
    ack();
    chk("udf_ack_irq", {7'd0, irq_o}, 8'h00);
    apb_write(8'h01, 8'h02, 0);
    apb_read(8'h01, 8'h00, 0, "udf_isr_clr");
    repeat (2) step();
    chk("udf_idle_irq", {7'd0, irq_o}, 8'h00);

    // simultaneous OVF+UDF: OVF first, then UDF re-raises
    apb_write(8'h00, 8'h03, 0);
    ovf_i = 1; udf_i = 1; step(); ovf_i = 0; udf_i = 0;
    step();
    chk("both_irq", {7'd0, irq_o}, 8'h01);
    chk("both_vec_ovf", vec_o, 8'h10);
    ack();
    apb_write(8'h01, 8'h01, 0);
    repeat (2) step();
    chk("both_irq_again", {7'd0, irq_o}, 8'h01);
    chk("both_vec_udf", vec_o, 8'h11);
    ack();
    apb_write(8'h01, 8'h02, 0);
    repeat (3) step();

    // pending while disabled, then enable
    apb_write(8'h00, 8'h00, 0);
    pulse_ovf();
    repeat (2) step();
    chk("dis_irq", {7'd0, irq_o}, 8'h00);
    apb_read(8'h01, 8'h01, 0, "dis_isr");
    apb_write(8'h00, 8'h01, 0);
    step();
    chk("en_irq", {7'd0, irq_o}, 8'h01);
    // cancel in REQ by clearing the flag
    apb_write(8'h01, 8'h01, 0);
    step();
    chk("cancel_irq", {7'd0, irq_o}, 8'h00);

    // set beats W1C on the same bit
    apb_write(8'h00, 8'h00, 0);
    apb_write(8'h01, 8'h02, 1);
    udf_i = 0;
    apb_read(8'h01, 8'h02, 0, "set_prio_isr");
    apb_write(8'h01, 8'h02, 0);
    apb_read(8'h01, 8'h00, 0, "set_prio_clr");

    // error accesses
    apb_read(8'h04, 8'h00, 0, "unmapped_rd");
    apb_write(8'h02, 8'hAA, 0);
    apb_read(8'h02, 8'h10, 0, "ivr_unchanged");

    // reset during REQ
    apb_write(8'h00, 8'h01, 0);
    pulse_ovf();
    step();
    chk("pre_rst_irq", {7'd0, irq_o}, 8'h01);
    presetn = 0;
    step();
    chk("mid_rst_irq", {7'd0, irq_o}, 8'h00);
    chk("mid_rst_vec", vec_o, 8'h00);
    presetn = 1;
    repeat (2) step();
    apb_read(8'h00, 8'h00, 0, "mid_rst_ier");

    // random traffic checked against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        irq_ack_i = 0;
        if ($urandom_range(0, 1) == 1)
          apb_write(8'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), 0);
        else
          apb_read(8'($urandom_range(0, 4)), 8'h00, 1, "rand_rd");
      end else begin
        if ($urandom_range(0, 3) == 0) ovf_i = ~ovf_i;
        if ($urandom_range(0, 3) == 0) udf_i = ~udf_i;
        irq_ack_i = ($urandom_range(0, 4) == 0);
        step();
      end
    end
    irq_ack_i = 0; ovf_i = 0; udf_i = 0;
    step();

`ifdef TIMER_INT_EVCNT_EN
    apb_write(8'h00, 8'h00, 0);
    apb_write(8'h03, 8'h00, 0);
    for (int i = 0; i < 300; i++) begin
      pulse_ovf();
      step();
    end
    apb_read(8'h03, 8'hFF, 0, "ecr_sat");
    apb_write(8'h03, 8'h5A, 0);
    apb_read(8'h03, 8'h00, 0, "ecr_clr");
`else
    apb_read(8'h03, 8'h00, 0, "ecr_absent");
    chk("ecr_absent_modelerr", {7'd0, exp_err(8'h03, 1'b0)}, 8'h01);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
